// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port 64-bit memory between the fetch and memory stages.
// Data has priority, fetch is forced after STARVE_MAX data grants, and stuck accesses time out.
module mem_port_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        if_req_i,
    input  logic [63:0] if_addr_i,
    output logic [63:0] if_rdata_o,
    output logic        if_valid_o,
    output logic        if_err_o,
    output logic        if_stall_o,
    input  logic        dm_req_i,
    input  logic        dm_we_i,
    input  logic [63:0] dm_addr_i,
    input  logic [63:0] dm_wdata_i,
    output logic [63:0] dm_rdata_o,
    output logic        dm_valid_o,
    output logic        dm_err_o,
    output logic        dm_stall_o,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [63:0] mem_addr_o,
    output logic [63:0] mem_wdata_o,
    input  logic [63:0] mem_rdata_i,
    input  logic        mem_ack_i
);
    localparam int unsigned StarveW = $clog2(STARVE_MAX + 1);
    localparam int unsigned TmoW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StGntI, StGntD} state_e;

    state_e               state_q, state_d;
    logic [StarveW-1:0]   starveCnt_q, starveCnt_d;
    logic [TmoW-1:0]      tmoCnt_q, tmoCnt_d;
    logic                 memReq_q, memReq_d;
    logic                 memWe_q, memWe_d;
    logic [63:0]          memAddr_q, memAddr_d;
    logic [63:0]          memWdata_q, memWdata_d;
    logic [63:0]          ifRdata_q, ifRdata_d;
    logic [63:0]          dmRdata_q, dmRdata_d;
    logic                 ifValid_q, ifValid_d;
    logic                 ifErr_q, ifErr_d;
    logic                 dmValid_q, dmValid_d;
    logic                 dmErr_q, dmErr_d;
    logic                 fetchForced;
    logic                 pickData;

    assign fetchForced = if_req_i && (starveCnt_q == StarveW'(STARVE_MAX));
    assign pickData    = dm_req_i && !fetchForced;

    always_comb begin
        state_d     = state_q;
        starveCnt_d = starveCnt_q;
        tmoCnt_d    = tmoCnt_q;
        memReq_d    = memReq_q;
        memWe_d     = memWe_q;
        memAddr_d   = memAddr_q;
        memWdata_d  = memWdata_q;
        ifRdata_d   = ifRdata_q;
        dmRdata_d   = dmRdata_q;
        ifValid_d   = 1'b0;
        ifErr_d     = 1'b0;
        dmValid_d   = 1'b0;
        dmErr_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!if_req_i) begin
                    starveCnt_d = '0;
                end
                // A requester finishing this cycle still wins arbitration but is not regranted,
                // so nobody is granted until its stale request has been dropped or re-presented.
                if (pickData) begin
                    if (!dm_valid_o) begin
                        state_d    = StGntD;
                        tmoCnt_d   = '0;
                        memReq_d   = 1'b1;
                        memWe_d    = dm_we_i;
                        memAddr_d  = dm_addr_i;
                        memWdata_d = dm_wdata_i;
                        if (if_req_i && (starveCnt_q < StarveW'(STARVE_MAX))) begin
                            starveCnt_d = starveCnt_q + StarveW'(1);
                        end
                    end
                end else if (if_req_i) begin
                    if (!if_valid_o) begin
                        state_d     = StGntI;
                        tmoCnt_d    = '0;
                        memReq_d    = 1'b1;
                        memWe_d     = 1'b0;
                        memAddr_d   = if_addr_i;
                        memWdata_d  = '0;
                        starveCnt_d = '0;
                    end
                end
            end
            StGntI, StGntD: begin
                if (mem_ack_i) begin
                    state_d  = StIdle;
                    memReq_d = 1'b0;
                    if (state_q == StGntD) begin
                        dmRdata_d = memWe_q ? 64'd0 : mem_rdata_i;
                        dmValid_d = 1'b1;
                    end else begin
                        ifRdata_d = mem_rdata_i;
                        ifValid_d = 1'b1;
                    end
                end else if (tmoCnt_q == TmoW'(TIMEOUT - 1)) begin
                    state_d  = StIdle;
                    memReq_d = 1'b0;
                    if (state_q == StGntD) begin
                        dmRdata_d = '0;
                        dmValid_d = 1'b1;
                        dmErr_d   = 1'b1;
                    end else begin
                        ifRdata_d = '0;
                        ifValid_d = 1'b1;
                        ifErr_d   = 1'b1;
                    end
                end else begin
                    tmoCnt_d = tmoCnt_q + TmoW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q     <= StIdle;
            starveCnt_q <= '0;
            tmoCnt_q    <= '0;
            memReq_q    <= 1'b0;
            memWe_q     <= 1'b0;
            memAddr_q   <= '0;
            memWdata_q  <= '0;
            ifRdata_q   <= '0;
            dmRdata_q   <= '0;
            ifValid_q   <= 1'b0;
            ifErr_q     <= 1'b0;
            dmValid_q   <= 1'b0;
            dmErr_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            starveCnt_q <= starveCnt_d;
            tmoCnt_q    <= tmoCnt_d;
            memReq_q    <= memReq_d;
            memWe_q     <= memWe_d;
            memAddr_q   <= memAddr_d;
            memWdata_q  <= memWdata_d;
            ifRdata_q   <= ifRdata_d;
            dmRdata_q   <= dmRdata_d;
            ifValid_q   <= ifValid_d;
            ifErr_q     <= ifErr_d;
            dmValid_q   <= dmValid_d;
            dmErr_q     <= dmErr_d;
        end
    end

    assign mem_req_o   = memReq_q;
    assign mem_we_o    = memWe_q;
    assign mem_addr_o  = memAddr_q;
    assign mem_wdata_o = memWdata_q;
    assign if_rdata_o  = ifRdata_q;
    assign if_valid_o  = ifValid_q;
    assign if_err_o    = ifErr_q;
    assign dm_rdata_o  = dmRdata_q;
    assign dm_valid_o  = dmValid_q;
    assign dm_err_o    = dmErr_q;
    assign if_stall_o  = if_req_i & ~ifValid_q;
    assign dm_stall_o  = dm_req_i & ~dmValid_q;

endmodule
